// File: rtl/mult_8x8_seq_ctrl.sv
// Sequential 8x8 multiplier controller: one shared 4x4 sub-multiplier is reused
// for the four partial products over four cycles, with a per-quadrant approximation level.
module mult_8x8_seq_ctrl #(
  parameter logic [7:0] DEF_CFG  = 8'b01_10_11_11,
  parameter bit         USE_PORT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a_in,
  input  logic [7:0]  b_in,
  input  logic [7:0]  cfg_in,
  output logic [3:0]  sub_a,
  output logic [3:0]  sub_b,
  output logic [1:0]  sub_mode,
  input  logic [7:0]  sub_prod,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] r_out,
  output logic        busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE; out_valid is high only in DONE and, once
  // raised, stays high with r_out stable until out_ready completes the transfer.

  typedef enum logic [2:0] {IDLE, Q0, Q1, Q2, Q3, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [7:0]  cfg_q;
  logic [15:0] acc;
  logic [15:0] r_q;
  logic [15:0] addend;
  logic [15:0] acc_sum;
  logic        accept;

  assign accept  = (state == IDLE) && in_valid;
  assign acc_sum = acc + addend;
  assign r_out   = r_q;

  always_comb begin
    state_nxt = state;
    sub_a     = 4'd0;
    sub_b     = 4'd0;
    sub_mode  = 2'd0;
    addend    = 16'd0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = Q0;
      end
      Q0: begin
        sub_a     = a_q[3:0];
        sub_b     = b_q[3:0];
        sub_mode  = cfg_q[1:0];
        addend    = {8'h00, sub_prod};
        state_nxt = Q1;
      end
      Q1: begin
        sub_a     = a_q[3:0];
        sub_b     = b_q[7:4];
        sub_mode  = cfg_q[3:2];
        addend    = {4'h0, sub_prod, 4'h0};
        state_nxt = Q2;
      end
      Q2: begin
        sub_a     = a_q[7:4];
        sub_b     = b_q[3:0];
        sub_mode  = cfg_q[5:4];
        addend    = {4'h0, sub_prod, 4'h0};
        state_nxt = Q3;
      end
      Q3: begin
        sub_a     = a_q[7:4];
        sub_b     = b_q[7:4];
        sub_mode  = cfg_q[7:6];
        addend    = {sub_prod, 8'h00};
        state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // r_q is a separate result register so r_out survives the acc clear at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_q   <= 8'd0;
      b_q   <= 8'd0;
      cfg_q <= 8'd0;
      acc   <= 16'd0;
      r_q   <= 16'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_q   <= a_in;
        b_q   <= b_in;
        cfg_q <= USE_PORT ? cfg_in : DEF_CFG;
        acc   <= 16'd0;
      end else if (state == Q0 || state == Q1 || state == Q2 || state == Q3) begin
        acc <= acc_sum;
      end
      if (state == Q3) r_q <= acc_sum;
    end
  end

endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// Directed bench for mult_8x8_seq_ctrl: one instance with the config port, one
// with the fixed default config, each driven by a behavioural 4x4 sub-multiplier.
module tb_mult_8x8_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  int          tests = 0;
  int          fails = 0;

  // instance with USE_PORT=1
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  a_in, b_in, cfg_in, sub_prod;
  logic [3:0]  sub_a, sub_b;
  logic [1:0]  sub_mode;
  logic [15:0] r_out;
  logic [1:0]  stub_sel;

  // instance with USE_PORT=0
  logic        in_valid_d0, in_ready_d0, out_valid_d0, out_ready_d0, busy_d0;
  logic [7:0]  a_in_d0, b_in_d0, cfg_in_d0, sub_prod_d0;
  logic [3:0]  sub_a_d0, sub_b_d0;
  logic [1:0]  sub_mode_d0;
  logic [15:0] r_out_d0;

  logic [3:0]  obs_a [4];
  logic [3:0]  obs_b [4];
  logic [1:0]  obs_m [4];
  logic [7:0]  pa [4];
  logic [7:0]  pb [4];
  logic [15:0] pr [4];

  always #5 clk = ~clk;

  mult_8x8_seq_ctrl #(.USE_PORT(1'b1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .cfg_in(cfg_in),
    .sub_a(sub_a), .sub_b(sub_b), .sub_mode(sub_mode), .sub_prod(sub_prod),
    .out_valid(out_valid), .out_ready(out_ready), .r_out(r_out), .busy(busy)
  );

  mult_8x8_seq_ctrl #(.DEF_CFG(8'b01_10_11_11), .USE_PORT(1'b0)) u_dut_d0 (
    .clk(clk), .rst(rst), .in_valid(in_valid_d0), .in_ready(in_ready_d0),
    .a_in(a_in_d0), .b_in(b_in_d0), .cfg_in(cfg_in_d0),
    .sub_a(sub_a_d0), .sub_b(sub_b_d0), .sub_mode(sub_mode_d0), .sub_prod(sub_prod_d0),
    .out_valid(out_valid_d0), .out_ready(out_ready_d0), .r_out(r_out_d0), .busy(busy_d0)
  );

  // Sub-multiplier models: exact, mode tag (mode*16), or an out-of-range 0xFF.
  always_comb begin
    case (stub_sel)
      2'd0:    sub_prod = {4'h0, sub_a} * {4'h0, sub_b};
      2'd1:    sub_prod = {2'b00, sub_mode, 4'h0};
      default: sub_prod = 8'hFF;
    endcase
  end
  assign sub_prod_d0 = {4'h0, sub_a_d0} * {4'h0, sub_b_d0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge with the DUT idle; returns at the negedge of cycle 5.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [15:0] exp_r, input logic rdy, input string tag);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    a_in      = a;
    b_in      = b;
    cfg_in    = c;
    out_ready = rdy;
    for (int q = 0; q < 4; q++) begin
      @(negedge clk);
      in_valid = 1'b0;
      a_in     = 8'($urandom_range(0, 255));
      b_in     = 8'($urandom_range(0, 255));
      cfg_in   = 8'($urandom_range(0, 255));
      obs_a[q] = sub_a;
      obs_b[q] = sub_b;
      obs_m[q] = sub_mode;
      check({tag, "_busy_flags"}, {29'd0, out_valid, in_ready, busy}, 32'b001);
    end
    @(negedge clk);
    check({tag, "_done_flags"}, {30'd0, out_valid, in_ready}, 32'b10);
    check({tag, "_r_out"}, {16'd0, r_out}, {16'd0, exp_r});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; stub_sel = 2'd0;
    in_valid = 0; out_ready = 0; a_in = 0; b_in = 0; cfg_in = 0;
    in_valid_d0 = 0; out_ready_d0 = 0; a_in_d0 = 0; b_in_d0 = 0; cfg_in_d0 = 0;
    repeat (2) @(negedge clk);
    check("rst_flags", {29'd0, in_ready, out_valid, busy}, 32'b100);
    check("rst_r_out", {16'd0, r_out}, 32'd0);
    check("rst_sub", {22'd0, sub_a, sub_b, sub_mode}, 32'd0);
    check("rst_d0_flags", {29'd0, in_ready_d0, out_valid_d0, busy_d0}, 32'b100);
    rst = 1'b0;

    // max operands, exact products
    do_op(8'd255, 8'd255, 8'd0, 16'd65025, 1'b1, "t1");
    @(negedge clk);
    check("t1_back_idle", {30'd0, out_valid, in_ready}, 32'b01);

    // quadrant ordering of nibbles and modes
    do_op(8'h3C, 8'hA5, 8'd0, 16'd9900, 1'b1, "t2");
    check("t2_nibble_seq", {obs_a[0], obs_b[0], obs_a[1], obs_b[1],
                            obs_a[2], obs_b[2], obs_a[3], obs_b[3]}, 32'hC5CA353A);
    check("t2_mode_seq", {24'd0, obs_m[0], obs_m[1], obs_m[2], obs_m[3]}, 32'h00);
    @(negedge clk);

    // mode-tagging stub
    stub_sel = 2'd1;
    do_op(8'h11, 8'h22, 8'b01_10_11_11, 16'd5424, 1'b1, "t3");
    check("t3_mode_seq", {24'd0, obs_m[0], obs_m[1], obs_m[2], obs_m[3]}, 32'hF9);
    @(negedge clk);

    // out-of-range approximate products wrap modulo 2^16
    stub_sel = 2'd2;
    do_op(8'd1, 8'd1, 8'd0, 16'd8159, 1'b1, "ovf");
    @(negedge clk);
    stub_sel = 2'd0;

    // backpressure: result held, inputs ignored
    do_op(8'd12, 8'd34, 8'd0, 16'd408, 1'b0, "t4");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_hold", {13'd0, out_valid, in_ready, busy, r_out}, {13'd0, 3'b101, 16'd408});
      in_valid = i[0];
      a_in     = 8'($urandom_range(0, 255));
      b_in     = 8'($urandom_range(0, 255));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_release", {29'd0, out_valid, in_ready, busy}, 32'b010);
    check("t4_r_out_kept", {16'd0, r_out}, 32'd408);
    @(negedge clk);
    check("t4_still_idle", {29'd0, out_valid, in_ready, busy}, 32'b010);

    // reset in Q2 discards the in-flight result
    in_valid = 1'b1; a_in = 8'h99; b_in = 8'h99;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5_q2_sub", {24'd0, sub_a, sub_b}, 32'h99);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5_after_rst", {29'd0, out_valid, in_ready, busy}, 32'b010);
    check("t5_r_out_clr", {16'd0, r_out}, 32'd0);
    @(negedge clk);
    check("t5_no_stale", {31'd0, out_valid}, 32'd0);
    do_op(8'd2, 8'd3, 8'd0, 16'd6, 1'b1, "t5");
    @(negedge clk);

    // back-to-back on the fixed-config instance
    pa[0] = 8'd255;  pb[0] = 8'd255;  pr[0] = 16'd65025;
    pa[1] = 8'h80;   pb[1] = 8'h02;   pr[1] = 16'd256;
    pa[2] = 8'h0F;   pb[2] = 8'hF0;   pr[2] = 16'd3600;
    pa[3] = 8'hAB;   pb[3] = 8'hCD;   pr[3] = 16'd35055;
    out_ready_d0 = 1'b1;
    in_valid_d0  = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      check("t6_accept_flags", {30'd0, in_ready_d0, out_valid_d0}, 32'b10);
      a_in_d0   = pa[k];
      b_in_d0   = pb[k];
      cfg_in_d0 = 8'($urandom_range(0, 255));
      for (int q = 0; q < 4; q++) begin
        @(negedge clk);
        obs_m[q]  = sub_mode_d0;
        a_in_d0   = 8'($urandom_range(0, 255));
        b_in_d0   = 8'($urandom_range(0, 255));
        cfg_in_d0 = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
      check("t6_out_valid", {31'd0, out_valid_d0}, 32'd1);
      check("t6_r_out", {16'd0, r_out_d0}, {16'd0, pr[k]});
      check("t6_def_mode_seq", {24'd0, obs_m[0], obs_m[1], obs_m[2], obs_m[3]}, 32'hF9);
    end
    in_valid_d0 = 1'b0;
    @(negedge clk);
    check("t6_end_idle", {30'd0, in_ready_d0, out_valid_d0}, 32'b10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
